rom_seq_reader: RTL and testbench

- Read-side initiator for the 16x8 ROM (cs / addr / read_en / data interface).
- On a start command it walks a run of consecutive ROM addresses, wrapping 15 -> 0, and drives cs, addr and read_en.
- It captures each returned byte and presents it downstream on a valid/ready handshake.
- Sits between the ROM instance and any byte consumer (display driver, serializer).

---
 rtl/rom_seq_reader_pkg.sv | 24 ++
 rtl/rom_seq_addr_gen.sv | 66 ++++++
 rtl/rom_seq_reader.sv | 175 +++++++++++++++++
 tb/tb_rom_seq_reader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_seq_reader_pkg.sv
// Shared definitions for the ROM sequential reader: sequencer state encodings,
// default widths and the wait-counter sizing helper.
package rom_seq_reader_pkg;

    localparam int ADDR_W_DEF    = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int READ_WAIT_DEF = 1;

    // READ_WAIT is at most 7, so three bits cover the wait counter
    localparam int WAIT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Terminal value of the wait counter for a given READ_WAIT
    function automatic logic [WAIT_W-1:0] wait_last(input int read_wait);
        return WAIT_W'(read_wait - 1);
    endfunction

endpackage

// File: rtl/rom_seq_addr_gen.sv
// Address / count bookkeeping for the ROM sequential reader.
// Holds the current ROM address (wrapping modulo 2**ADDR_W), the number of
// bytes still to deliver, and the per-byte wait counter used while the ROM
// address is being held.
module rom_seq_addr_gen
    import rom_seq_reader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int READ_WAIT = READ_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              tick,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W:0]   load_count,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_next,
    output logic              last,
    output logic              wait_done
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign wait_done = (wait_cnt_q == wait_last(READ_WAIT));
    assign last      = (remaining_q == (ADDR_W+1)'(1));
    assign addr      = addr_q;
    assign addr_next = addr_d;

    // Next address / remaining count / wait count
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wait_cnt_d  = '0;
        if (load) begin
            addr_d      = load_addr;
            remaining_d = load_count;
        end else if (step) begin
            // Natural overflow of the ADDR_W-bit register gives the 15 -> 0 wrap
            addr_d      = addr_q + ADDR_W'(1);
            remaining_d = remaining_q - (ADDR_W+1)'(1);
        end
        // Counter runs only while the address is being held and restarts at 0
        // for every new byte
        if (tick && !wait_done) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/rom_seq_reader.sv
// ROM sequential reader: walks a run of consecutive ROM addresses (wrapping),
// issues cs/read_en/addr to the ROM, captures each byte and hands it
// downstream on a valid/ready handshake.
// Optional feature: define ROM_SEQ_CHECKSUM_EN to add the 'checksum' output,
// the modulo-2**DATA_W sum of the bytes accepted in the run.
module rom_seq_reader
    import rom_seq_reader_pkg::*;
#(
    parameter int READ_WAIT = READ_WAIT_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic              rom_cs,
    output logic              rom_read_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef ROM_SEQ_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_e state_q, state_d;

    logic              rom_cs_q, rom_cs_d;
    logic              rom_read_en_q, rom_read_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] gen_addr, gen_addr_next;
    logic              gen_last, gen_wait_done;
    logic              gen_load, gen_step, gen_tick;
    logic              start_ok, xfer;

    assign start_ok = (state_q == ST_IDLE) && start;
    assign xfer     = out_valid_q && out_ready;
    // An abort wins over a concurrent handshake, so the byte is not counted
    assign gen_load = start_ok && (count != '0);
    assign gen_step = (state_q == ST_HOLD) && xfer && !abort;
    assign gen_tick = (state_q == ST_ISSUE) && !abort;

    rom_seq_addr_gen #(
        .ADDR_W    (ADDR_W),
        .READ_WAIT (READ_WAIT)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (gen_load),
        .step       (gen_step),
        .tick       (gen_tick),
        .load_addr  (start_addr),
        .load_count (count),
        .addr       (gen_addr),
        .addr_next  (gen_addr_next),
        .last       (gen_last),
        .wait_done  (gen_wait_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (count == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (gen_wait_done) state_d = ST_HOLD;
            ST_HOLD:  if (xfer) state_d = gen_last ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // Output decode: every output is registered, so it is derived from the
    // state being entered rather than the current one
    always_comb begin
        rom_cs_d      = (state_d == ST_ISSUE);
        rom_read_en_d = (state_d == ST_ISSUE);
        rom_addr_d    = (state_d == ST_ISSUE) ? gen_addr_next : '0;
        out_valid_d   = (state_d == ST_HOLD);
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
        out_data_d    = out_data_q;
        out_addr_d    = out_addr_q;
        // Capture on the edge that ends the last wait cycle
        if ((state_q == ST_ISSUE) && gen_wait_done && !abort) begin
            out_data_d = rom_data;
            out_addr_d = gen_addr;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_cs_q      <= 1'b0;
            rom_read_en_q <= 1'b0;
            rom_addr_q    <= '0;
            out_data_q    <= '0;
            out_addr_q    <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            rom_cs_q      <= rom_cs_d;
            rom_read_en_q <= rom_read_en_d;
            rom_addr_q    <= rom_addr_d;
            out_data_q    <= out_data_d;
            out_addr_q    <= out_addr_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign rom_cs      = rom_cs_q;
    assign rom_read_en = rom_read_en_q;
    assign rom_addr    = rom_addr_q;
    assign out_data    = out_data_q;
    assign out_addr    = out_addr_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef ROM_SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    // Run checksum: cleared by an accepted start, accumulates every byte
    // handed downstream; an abort leaves the partial sum in place
    always_comb begin
        sum_d = sum_q;
        if (start_ok) begin
            sum_d = '0;
        end else if (gen_step) begin
            sum_d = sum_q + out_data_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_rom_seq_reader.sv
// Testbench for rom_seq_reader. The main instance (READ_WAIT=1) is driven by a
// procedural run task that also states, cycle by cycle, what the outputs must
// be; a negedge compare process checks them. A second instance (READ_WAIT=3)
// checks the hold length per byte. Build with ROM_SEQ_CHECKSUM_EN to cover the
// checksum output as well.
module tb_rom_seq_reader;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int RW1 = 1;
    localparam int RW3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance ----------------
    logic          start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   count = '0;
    logic          rom_cs, rom_read_en, out_valid, busy, done;
    logic [AW-1:0] rom_addr, out_addr;
    logic [DW-1:0] rom_data, out_data;
`ifdef ROM_SEQ_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    // ROM model: data = {addr, ~addr}
    assign rom_data = {rom_addr, ~rom_addr};

    rom_seq_reader #(.READ_WAIT(RW1), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .count(count), .abort(abort), .rom_cs(rom_cs), .rom_read_en(rom_read_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data),
        .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
`ifdef ROM_SEQ_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    // ---------------- READ_WAIT=3 instance ----------------
    logic          start3 = 1'b0, abort3 = 1'b0, ready3 = 1'b1;
    logic [AW-1:0] start_addr3 = '0;
    logic [AW:0]   count3 = '0;
    logic          rom_cs3, rom_read_en3, out_valid3, busy3, done3;
    logic [AW-1:0] rom_addr3, out_addr3;
    logic [DW-1:0] rom_data3, out_data3;
`ifdef ROM_SEQ_CHECKSUM_EN
    logic [DW-1:0] checksum3;
`endif

    assign rom_data3 = {rom_addr3, ~rom_addr3};

    rom_seq_reader #(.READ_WAIT(RW3), .ADDR_W(AW), .DATA_W(DW)) u_rw3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .start_addr(start_addr3),
        .count(count3), .abort(abort3), .rom_cs(rom_cs3), .rom_read_en(rom_read_en3),
        .rom_addr(rom_addr3), .rom_data(rom_data3), .out_data(out_data3),
        .out_addr(out_addr3), .out_valid(out_valid3), .out_ready(ready3),
        .busy(busy3), .done(done3)
`ifdef ROM_SEQ_CHECKSUM_EN
        , .checksum(checksum3)
`endif
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs of the main instance for the current cycle
    logic          chk_en = 1'b1;
    logic          exp_cs = 1'b0, exp_valid = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
    logic [AW-1:0] exp_raddr = '0, exp_oaddr = '0;
    logic [DW-1:0] exp_data = '0;
    logic [DW-1:0] exp_sum = '0;
    logic          chk_sum = 1'b1;

    logic [AW+DW-1:0] got_q[$];
    int done_cnt = 0;
    int cs_cnt = 0;

    // Per-cycle compare for the main instance
    always @(negedge clk) begin
        if (chk_en) begin
            check("rom_cs", rom_cs, exp_cs);
            check("rom_read_en", rom_read_en, exp_cs);
            check("rom_addr", rom_addr, exp_raddr);
            check("out_valid", out_valid, exp_valid);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (exp_valid) begin
                check("out_data", out_data, exp_data);
                check("out_addr", out_addr, exp_oaddr);
            end
`ifdef ROM_SEQ_CHECKSUM_EN
            if (chk_sum) check("checksum", checksum, exp_sum);
`endif
            if (out_valid && out_ready && !abort) begin
                got_q.push_back({out_addr, out_data});
                $display("xfer addr=%0d data=0x%02h", out_addr, out_data);
            end
            if (done) done_cnt++;
            if (rom_cs) cs_cnt++;
        end
    end

    // READ_WAIT=3 instance: cs run length, address stability, byte sequence
    logic          chk3 = 1'b1;
    int            run3 = 0;
    int            runs3 = 0;
    int            xfers3 = 0;
    logic [AW-1:0] hold_addr3 = '0;
    logic [AW-1:0] exp3_addr = 4'd5;

    always @(negedge clk) begin
        if (chk3 && rst_n) begin
            check("rw3_read_en", rom_read_en3, rom_cs3);
            if (rom_cs3) begin
                if (run3 == 0) hold_addr3 = rom_addr3;
                else check("rw3_addr_stable", rom_addr3, hold_addr3);
                run3++;
            end else if (run3 > 0) begin
                check("rw3_cs_len", run3, RW3);
                runs3++;
                run3 = 0;
            end
            if (out_valid3 && ready3) begin
                check("rw3_out_addr", out_addr3, exp3_addr);
                check("rw3_out_data", out_data3, {exp3_addr, ~exp3_addr});
                $display("xfer3 addr=%0d data=0x%02h", out_addr3, out_data3);
                exp3_addr = exp3_addr + 4'd1;
                xfers3++;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        exp_cs = 1'b0; exp_raddr = '0; exp_valid = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; chk_sum = 1'b1;
    endtask

    // One run: drives the stimulus and states the expected outputs for every
    // cycle. stall0 < 0 means random stall on byte 0 (like the others).
    task automatic run(input logic [AW-1:0] sa, input int cnt, input int stall0,
                       input int stall_max, input int abort_byte, input bit abort_hold);
        logic [AW-1:0] a;
        int k;
        set_idle();
        start = 1'b1; start_addr = sa; count = (AW+1)'(cnt);
        abort = 1'($urandom_range(0, 1));          // abort in IDLE must be ignored
        step();
        start = 1'b0; abort = 1'b0;
        start_addr = AW'($urandom_range(0, 15));   // must not matter once running
        count = (AW+1)'($urandom_range(0, 31));
        exp_sum = '0; chk_sum = 1'b0; exp_busy = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            a = sa + AW'(i);
            for (int w = 0; w < RW1; w++) begin
                exp_cs = 1'b1; exp_raddr = a; exp_valid = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));  // start while busy is ignored
                if (i == abort_byte && !abort_hold) begin
                    abort = 1'b1;
                    step();
                    abort = 1'b0; start = 1'b0; out_ready = 1'b0;
                    set_idle();
                    return;
                end
                step();
            end
            start = 1'b0;
            exp_cs = 1'b0; exp_raddr = '0; exp_valid = 1'b1;
            exp_data = {a, ~a}; exp_oaddr = a;
            if (i == 0 && stall0 >= 0) k = stall0;
            else k = $urandom_range(0, stall_max);
            for (int j = 0; j < k; j++) begin
                out_ready = 1'b0;
                step();
            end
            out_ready = 1'b1;
            if (i == abort_byte && abort_hold) begin
                abort = 1'b1;
                step();
                abort = 1'b0; out_ready = 1'b0;
                set_idle();
                return;
            end
            step();
            exp_sum = exp_sum + {a, ~a};
        end
        out_ready = 1'($urandom_range(0, 1));
        exp_cs = 1'b0; exp_raddr = '0; exp_valid = 1'b0;
        exp_done = 1'b1; exp_busy = 1'b1; chk_sum = 1'b1;
        step();
        set_idle();
        out_ready = 1'b0; start = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ab;
        int cnt_r;
        set_idle();
        step(); step();
        // Reset state
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        rst_n = 1'b1;
        step();

        // Basic: 0x78 @7, 0x87 @8
        got_q.delete(); done_cnt = 0;
        run(4'd7, 2, 0, 0, -1, 1'b0);
        check("basic_n", got_q.size(), 2);
        check("basic_b0", got_q[0], 12'h778);
        check("basic_b1", got_q[1], 12'h887);
        check("basic_done_cnt", done_cnt, 1);

        // Wrap 14,15,0,1
        got_q.delete();
        run(4'd14, 4, 0, 0, -1, 1'b0);
        check("wrap_n", got_q.size(), 4);
        check("wrap_b0", got_q[0], 12'hEE1);
        check("wrap_b1", got_q[1], 12'hFF0);
        check("wrap_b2", got_q[2], 12'h00F);
        check("wrap_b3", got_q[3], 12'h11E);
`ifdef ROM_SEQ_CHECKSUM_EN
        check("wrap_checksum", checksum, 8'hFE);
`endif

        // Back-pressure: 5 stall cycles on the first byte
        got_q.delete(); cs_cnt = 0;
        run(4'd0, 2, 5, 0, -1, 1'b0);
        check("bp_b0", got_q[0], 12'h00F);
        check("bp_b1", got_q[1], 12'h11E);
        check("bp_cs_cycles", cs_cnt, 2);

        // count = 0: no ROM access, one done
        cs_cnt = 0; done_cnt = 0;
        run(4'd9, 0, 0, 0, -1, 1'b0);
        check("cnt0_cs", cs_cnt, 0);
        check("cnt0_done", done_cnt, 1);

        // Abort during second ISSUE, then an immediate new start
        got_q.delete(); done_cnt = 0;
        run(4'd2, 4, 0, 0, 1, 1'b0);
        check("abort_n", got_q.size(), 1);
        check("abort_done", done_cnt, 0);
        run(4'd5, 1, 0, 0, -1, 1'b0);
        check("after_abort_b0", got_q[1], 12'h55A);
        check("after_abort_done", done_cnt, 1);

        // Abort beats a simultaneous transfer in HOLD
        got_q.delete(); done_cnt = 0;
        run(4'd10, 3, 0, 0, 1, 1'b1);
        check("abort_hold_n", got_q.size(), 1);
        check("abort_hold_done", done_cnt, 0);

        // count = 16 reads every address once
        got_q.delete(); cs_cnt = 0;
        run(4'd3, 16, -1, 2, -1, 1'b0);
        check("full_n", got_q.size(), 16);
        check("full_cs", cs_cnt, 16);

        // Asynchronous reset mid-HOLD
        set_idle();
        start = 1'b1; start_addr = 4'd3; count = 5'd2; out_ready = 1'b0;
        step();
        start = 1'b0; chk_sum = 1'b0;
        exp_busy = 1'b1; exp_cs = 1'b1; exp_raddr = 4'd3;
        step();
        exp_cs = 1'b0; exp_raddr = '0; exp_valid = 1'b1;
        exp_data = 8'h3C; exp_oaddr = 4'd3;
        @(negedge clk); #1;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_rom_cs", rom_cs, 0);
        check("arst_rom_read_en", rom_read_en, 0);
        check("arst_rom_addr", rom_addr, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_addr", out_addr, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
`ifdef ROM_SEQ_CHECKSUM_EN
        check("arst_checksum", checksum, 0);
`endif
        step(); step();
        rst_n = 1'b1;
        set_idle(); exp_sum = '0;
        chk_en = 1'b1;
        step();

        // READ_WAIT=3: cs high for exactly 3 cycles per byte
        start3 = 1'b1; start_addr3 = 4'd5; count3 = 5'd3;
        step();
        start3 = 1'b0;
        for (int n = 0; n < 60 && !done3; n++) step();
        check("rw3_done_seen", done3, 1);
        step(); step();
        check("rw3_runs", runs3, 3);
        check("rw3_xfers", xfers3, 3);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            cnt_r = $urandom_range(0, 16);
            ab = -1;
            if (cnt_r > 0 && $urandom_range(0, 4) == 0) ab = $urandom_range(0, cnt_r - 1);
            run(AW'($urandom_range(0, 15)), cnt_r, -1, 3, ab, 1'($urandom_range(0, 1)));
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound on simulation time
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
